// File: rtl/mem_port_ctrl.sv
// Memory front end: one access at a time, parked address before every issue.
// Out-of-range requests return an error response without touching the memory.
module mem_port_ctrl #(
  parameter  int data_length = 32,
  parameter  int mem_length  = 64,
  localparam int AW = (mem_length > 1) ? $clog2(mem_length) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [AW-1:0]          req_addr,
  input  logic [data_length-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [data_length-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_we,
  output logic [data_length-1:0] mem_wdata,
  input  logic [data_length-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    PARK,
    ISSUE,
    RESP
  } state_e;

  localparam logic [AW:0] LEN = (AW+1)'(mem_length);

  state_e                 state_q, state_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [data_length-1:0] wdata_q, wdata_d;
  logic [data_length-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic [AW-1:0]          maddr_q, maddr_d;
  logic                   mwe_q, mwe_d;
  logic                   oor;

  assign oor = {1'b0, req_addr} >= LEN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      maddr_q <= '0;
      mwe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      maddr_q <= maddr_d;
      mwe_q   <= mwe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    maddr_d = maddr_q;
    mwe_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (oor) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = PARK;
            // flip bit 0 so the real access is always an address change
            maddr_d = req_addr ^ AW'(1);
          end
        end
      end
      PARK: begin
        state_d = ISSUE;
        maddr_d = addr_q;
        mwe_d   = we_q;
      end
      ISSUE: begin
        state_d = RESP;
        rdata_d = mem_rdata;
        err_d   = 1'b0;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = ~rst & (state_q == IDLE);
  assign rsp_valid = ~rst & (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_addr  = maddr_q;
  assign mem_we    = ~rst & mwe_q;
  assign mem_wdata = wdata_q;

endmodule
